// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the writeback queue and its forwarding lookup.
//   XLEN_DEF    : default data / PC width
//   RA_W_DEF    : default register address width
//   PC_STEP_DEF : default sequential PC increment
//   head_state_e: handshake state of the entry at the queue head
//   wb_entry_t  : layout of one queued writeback entry at the default widths
package core_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RA_W_DEF    = 5;
    localparam int PC_STEP_DEF = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_REG = 2'd2,
        WAIT_PC  = 2'd3
    } head_state_e;

    typedef struct packed {
        logic [RA_W_DEF-1:0] rd;
        logic                rd_wen;
        logic [XLEN_DEF-1:0] data;
        logic [XLEN_DEF-1:0] npc;
    } wb_entry_t;

endpackage

// File: rtl/core_wb_fwd_lookup.sv
// core_wb_fwd_lookup: youngest-match search over the writeback queue for one
// decode read port.
//   query     : register address being read by decode
//   head_addr : slot index of the oldest entry
//   live      : per-slot flag, slot holds a pending entry that writes rd
//   rd_flat   : per-slot destination register, slot s at [s*RA_W +: RA_W]
//   data_flat : per-slot write data, slot s at [s*XLEN +: XLEN]
//   hit       : some pending write targets query
//   data      : data of the youngest such write, 0 when no hit
module core_wb_fwd_lookup #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RA_W  = 5
) (
    input  logic [RA_W-1:0]          query,
    input  logic [$clog2(DEPTH)-1:0] head_addr,
    input  logic [DEPTH-1:0]         live,
    input  logic [DEPTH*RA_W-1:0]    rd_flat,
    input  logic [DEPTH*XLEN-1:0]    data_flat,
    output logic                     hit,
    output logic [XLEN-1:0]          data
);

    localparam int AW = $clog2(DEPTH);

    // Walk from oldest to youngest so a later match overrides an earlier one.
    // Register 0 is hardwired, so it never forwards.
    always_comb begin
        logic [AW-1:0] idx;
        idx  = '0;
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_addr + AW'(i);
            if (live[idx] && (query != '0) &&
                (rd_flat[int'(idx)*RA_W +: RA_W] == query)) begin
                hit  = 1'b1;
                data = data_flat[int'(idx)*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/core_wb_queue.sv
// core_wb_queue: in-order writeback queue between MEM and the register file / PC.
//   clk, rst                        : clock, synchronous active-high reset
//   in_valid/in_ready, in_*         : retired-result handshake from MEM
//   flush                           : drop every entry except an in-flight head
//   wb_reg_wen/addr/din, reg_done   : register-file write request and acknowledge
//   wb_pc_wen/wb_pcin, pc_done      : PC write request and acknowledge
//   fwd_rs1/2 -> fwd_hit1/2, data1/2: newest pending rd value for decode
//   retire_cnt                      : number of retired entries (wraps)
//   empty                           : queue holds no entries
module core_wb_queue
    import core_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int DEPTH   = 4,
    parameter int RA_W    = RA_W_DEF,
    parameter int PC_STEP = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [RA_W-1:0] in_rd,
    input  logic            in_jmp,
    input  logic [XLEN-1:0] in_target,
    input  logic            in_link,
    input  logic            in_load,
    input  logic [XLEN-1:0] in_load_data,
    input  logic            in_computed,
    input  logic [XLEN-1:0] in_value,
    input  logic            flush,
    output logic            wb_reg_wen,
    output logic [RA_W-1:0] wb_rd_addr,
    output logic [XLEN-1:0] wb_rd_din,
    input  logic            wb_reg_done,
    output logic            wb_pc_wen,
    output logic [XLEN-1:0] wb_pcin,
    input  logic            pc_done,
    input  logic [RA_W-1:0] fwd_rs1,
    input  logic [RA_W-1:0] fwd_rs2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
    output logic [31:0]     retire_cnt,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);

    logic [RA_W-1:0] q_rd     [DEPTH];
    logic            q_rd_wen [DEPTH];
    logic [XLEN-1:0] q_data   [DEPTH];
    logic [XLEN-1:0] q_npc    [DEPTH];

    logic [AW:0]     head, tail, count;
    logic [AW-1:0]   head_addr, tail_addr;
    logic            full, accept, retire, gap, reg_ok;
    head_state_e     state, next_state;

    logic [XLEN-1:0] seq_pc, new_npc, new_data;
    logic            new_rd_wen;

    assign head_addr = head[AW-1:0];
    assign tail_addr = tail[AW-1:0];
    assign count     = tail - head;
    assign full      = (head_addr == tail_addr) && (head[AW] != tail[AW]);
    assign empty     = (head == tail);
    assign in_ready  = !full;
    // A flush in the same cycle swallows the incoming result.
    assign accept    = in_valid && in_ready && !flush;

    // Entry fields are resolved at enqueue so the head only stores final values.
    always_comb begin
        seq_pc     = in_pc + XLEN'(PC_STEP);
        new_npc    = in_jmp ? in_target : seq_pc;
        new_data   = in_computed ? in_value : (in_link ? seq_pc : (in_load ? in_load_data : '0));
        new_rd_wen = (in_computed || in_link || in_load) && (in_rd != '0);
    end

    // Head and tail pointers plus the retire counter. A flush keeps the head
    // only when it is mid-handshake; a simultaneous retire then empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            retire_cnt <= '0;
        end else begin
            if (retire) begin
                head       <= head + 1'b1;
                retire_cnt <= retire_cnt + 32'd1;
            end
            if (flush) begin
                tail <= (state != IDLE) ? head + 1'b1 : head;
            end else if (accept) begin
                tail <= tail + 1'b1;
            end
        end
    end

    // Entry storage; stale slots are harmless because the pointers define validity.
    always_ff @(posedge clk) begin
        if (accept) begin
            q_rd[tail_addr]     <= in_rd;
            q_rd_wen[tail_addr] <= new_rd_wen;
            q_data[tail_addr]   <= new_data;
            q_npc[tail_addr]    <= new_npc;
        end
    end

    // Head state register. gap holds both requests low for one cycle after a
    // retire so each write port sees a gap between consecutive entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gap   <= 1'b0;
        end else begin
            state <= next_state;
            gap   <= retire && (next_state == ISSUE);
        end
    end

    // Head next-state logic. An entry without a register write treats the
    // register side as already acknowledged. Dones are ignored during gap.
    always_comb begin
        next_state = state;
        retire     = 1'b0;
        reg_ok     = !q_rd_wen[head_addr] || wb_reg_done;
        case (state)
            IDLE: begin
                if (accept) next_state = ISSUE;
            end
            ISSUE: begin
                if (!gap) begin
                    if (reg_ok && pc_done)  retire     = 1'b1;
                    else if (pc_done)       next_state = WAIT_REG;
                    else if (reg_ok)        next_state = WAIT_PC;
                end
            end
            WAIT_REG: begin
                if (wb_reg_done) retire = 1'b1;
            end
            WAIT_PC: begin
                if (pc_done) retire = 1'b1;
            end
            default: next_state = IDLE;
        endcase
        if (retire) begin
            next_state = (((count != (AW+1)'(1)) || accept) && !flush) ? ISSUE : IDLE;
        end
    end

    // Write-port outputs come straight from the head slot and the head state.
    always_comb begin
        wb_reg_wen = 1'b0;
        wb_pc_wen  = 1'b0;
        wb_rd_addr = '0;
        wb_rd_din  = '0;
        wb_pcin    = '0;
        if (state != IDLE) begin
            wb_rd_addr = q_rd[head_addr];
            wb_rd_din  = q_data[head_addr];
            wb_pcin    = q_npc[head_addr];
            if (!gap) begin
                wb_pc_wen  = (state == ISSUE) || (state == WAIT_PC);
                wb_reg_wen = ((state == ISSUE) || (state == WAIT_REG)) && q_rd_wen[head_addr];
            end
        end
    end

    // Forwarding view of the queue: a slot is live when it lies between head
    // and tail and its entry writes a register.
    logic [DEPTH-1:0]      live;
    logic [DEPTH*RA_W-1:0] rd_flat;
    logic [DEPTH*XLEN-1:0] data_flat;

    always_comb begin
        logic [AW-1:0] offset;
        offset    = '0;
        live      = '0;
        rd_flat   = '0;
        data_flat = '0;
        for (int s = 0; s < DEPTH; s++) begin
            offset                   = AW'(s) - head_addr;
            live[s]                  = q_rd_wen[s] && ({1'b0, offset} < count);
            rd_flat[s*RA_W +: RA_W]  = q_rd[s];
            data_flat[s*XLEN +: XLEN] = q_data[s];
        end
    end

    core_wb_fwd_lookup #(.XLEN(XLEN), .DEPTH(DEPTH), .RA_W(RA_W)) u_fwd1 (
        .query     (fwd_rs1),
        .head_addr (head_addr),
        .live      (live),
        .rd_flat   (rd_flat),
        .data_flat (data_flat),
        .hit       (fwd_hit1),
        .data      (fwd_data1)
    );

    core_wb_fwd_lookup #(.XLEN(XLEN), .DEPTH(DEPTH), .RA_W(RA_W)) u_fwd2 (
        .query     (fwd_rs2),
        .head_addr (head_addr),
        .live      (live),
        .rd_flat   (rd_flat),
        .data_flat (data_flat),
        .hit       (fwd_hit2),
        .data      (fwd_data2)
    );

endmodule

// File: tb/tb_core_wb_queue.sv
// tb_core_wb_queue: self-checking bench for core_wb_queue.
// Directed table of single-entry vectors, hand-written multi-cycle sequences
// (staggered acks, fill, forwarding, flush, reset mid-handshake), then random
// traffic compared against a queue-based reference model.
module tb_core_wb_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_jmp;
    logic [31:0] in_target;
    logic        in_link;
    logic        in_load;
    logic [31:0] in_load_data;
    logic        in_computed;
    logic [31:0] in_value;
    logic        flush;
    logic        wb_reg_wen;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_rd_din;
    logic        wb_reg_done;
    logic        wb_pc_wen;
    logic [31:0] wb_pcin;
    logic        pc_done;
    logic [4:0]  fwd_rs1, fwd_rs2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [31:0] retire_cnt;
    logic        empty;

    core_wb_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
        .in_jmp(in_jmp), .in_target(in_target), .in_link(in_link), .in_load(in_load),
        .in_load_data(in_load_data), .in_computed(in_computed), .in_value(in_value),
        .flush(flush),
        .wb_reg_wen(wb_reg_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_din(wb_rd_din),
        .wb_reg_done(wb_reg_done), .wb_pc_wen(wb_pc_wen), .wb_pcin(wb_pcin),
        .pc_done(pc_done),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .retire_cnt(retire_cnt), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        jmp;
        logic [31:0] target;
        logic        link;
        logic        load;
        logic [31:0] ld;
        logic        comp;
        logic [31:0] val;
        logic        exp_reg_wen;
        logic [31:0] exp_din;
        logic [31:0] exp_pcin;
    } vec_t;

    typedef struct {
        logic [31:0] npc;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [31:0] data;
    } ment_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        in_valid     = 1'b1;
        in_pc        = v.pc;
        in_rd        = v.rd;
        in_jmp       = v.jmp;
        in_target    = v.target;
        in_link      = v.link;
        in_load      = v.load;
        in_load_data = v.ld;
        in_computed  = v.comp;
        in_value     = v.val;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkComp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val);
        vec_t v;
        v = '{pc, rd, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, val, 1'b1, val, pc + 32'd4};
        return v;
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, " empty"},      {31'd0, empty},      32'd1);
        checkOutput({tag, " in_ready"},   {31'd0, in_ready},   32'd1);
        checkOutput({tag, " reg_wen"},    {31'd0, wb_reg_wen}, 32'd0);
        checkOutput({tag, " pc_wen"},     {31'd0, wb_pc_wen},  32'd0);
        checkOutput({tag, " rd_addr"},    {27'd0, wb_rd_addr}, 32'd0);
        checkOutput({tag, " rd_din"},     wb_rd_din,           32'd0);
        checkOutput({tag, " pcin"},       wb_pcin,             32'd0);
        checkOutput({tag, " retire_cnt"}, retire_cnt,          32'd0);
    endtask

    // Watchdog keeps the run bounded even if the design wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    vec_t  vecs[8];
    ment_t mq[$];
    logic [31:0] seen_pcin[4];

    initial begin
        int unsigned exp_cnt;
        int          n_seen;
        vec_t        v;

        rst = 1'b1; in_valid = 0; in_pc = 0; in_rd = 0; in_jmp = 0; in_target = 0;
        in_link = 0; in_load = 0; in_load_data = 0; in_computed = 0; in_value = 0;
        flush = 0; wb_reg_done = 0; pc_done = 0; fwd_rs1 = 0; fwd_rs2 = 0;

        vecs[0] = '{32'h100, 5'd5, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b1, 32'hDEAD, 1'b1, 32'hDEAD, 32'h104};
        vecs[1] = '{32'h200, 5'd1, 1'b1, 32'h400,  1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h204,  32'h400};
        vecs[2] = '{32'h200, 5'd0, 1'b1, 32'h400,  1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    32'h400};
        vecs[3] = '{32'h300, 5'd3, 1'b0, 32'h0,    1'b0, 1'b1, 32'h1234, 1'b0, 32'h0,    1'b1, 32'h1234, 32'h304};
        vecs[4] = '{32'h340, 5'd4, 1'b0, 32'h0,    1'b1, 1'b1, 32'h88,   1'b1, 32'h77,   1'b1, 32'h77,   32'h344};
        vecs[5] = '{32'h380, 5'd6, 1'b1, 32'h1000, 1'b1, 1'b1, 32'h99,   1'b0, 32'h0,    1'b1, 32'h384,  32'h1000};
        vecs[6] = '{32'h3C0, 5'd9, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h0,    32'h3C4};
        vecs[7] = '{32'hFFFFFFFC, 5'd31, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,    1'b1, 32'h0,    32'h0};

        // ---------------- reset ----------------
        tick(); tick();
        rst = 1'b0;
        #1;
        checkResetState("reset");
        exp_cnt = 0;

        // ---------------- table-driven single entries, dones tied high ----------------
        wb_reg_done = 1'b1; pc_done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            tick();
            in_valid = 1'b0;
            #1;
            checkOutput($sformatf("vec%0d reg_wen", i), {31'd0, wb_reg_wen}, {31'd0, vecs[i].exp_reg_wen});
            checkOutput($sformatf("vec%0d pc_wen", i),  {31'd0, wb_pc_wen},  32'd1);
            checkOutput($sformatf("vec%0d pcin", i),    wb_pcin,             vecs[i].exp_pcin);
            if (vecs[i].exp_reg_wen) begin
                checkOutput($sformatf("vec%0d rd_addr", i), {27'd0, wb_rd_addr}, {27'd0, vecs[i].rd});
                checkOutput($sformatf("vec%0d rd_din", i),  wb_rd_din,           vecs[i].exp_din);
            end
            tick();
            exp_cnt++;
            checkOutput($sformatf("vec%0d retire_cnt", i), retire_cnt, exp_cnt);
            checkOutput($sformatf("vec%0d empty", i),      {31'd0, empty},     32'd1);
            checkOutput($sformatf("vec%0d pc_wen off", i), {31'd0, wb_pc_wen}, 32'd0);
        end

        // ---------------- staggered acks ----------------
        wb_reg_done = 1'b0; pc_done = 1'b0;
        applyStimulus(mkComp(32'h600, 5'd12, 32'hCAFE));
        tick();                                   // cycle +1
        in_valid = 1'b0;
        tick();                                   // cycle +2
        pc_done = 1'b1;
        #1;
        checkOutput("stag c2 pc_wen", {31'd0, wb_pc_wen}, 32'd1);
        tick();                                   // cycle +3
        pc_done = 1'b0;
        #1;
        checkOutput("stag c3 pc_wen",  {31'd0, wb_pc_wen},  32'd0);
        checkOutput("stag c3 reg_wen", {31'd0, wb_reg_wen}, 32'd1);
        tick(); tick();                           // cycle +5
        wb_reg_done = 1'b1;
        #1;
        checkOutput("stag c5 reg_wen", {31'd0, wb_reg_wen}, 32'd1);
        checkOutput("stag c5 rd_addr", {27'd0, wb_rd_addr}, 32'd12);
        checkOutput("stag c5 rd_din",  wb_rd_din,           32'hCAFE);
        tick();                                   // cycle +6
        wb_reg_done = 1'b0;
        #1;
        exp_cnt++;
        checkOutput("stag c6 reg_wen",    {31'd0, wb_reg_wen}, 32'd0);
        checkOutput("stag c6 retire_cnt", retire_cnt,          exp_cnt);
        checkOutput("stag c6 empty",      {31'd0, empty},      32'd1);

        // ---------------- fill to DEPTH, then drain ----------------
        for (int k = 0; k < 4; k++) begin
            applyStimulus(mkComp(32'h1000 + 32'h10 * k, 5'(k + 1), 32'(k)));
            tick();
        end
        applyStimulus(mkComp(32'h2000, 5'd20, 32'h55));
        #1;
        checkOutput("fill in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("fill in_ready hold", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        wb_reg_done = 1'b1; pc_done = 1'b1;
        n_seen = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (wb_pc_wen && n_seen < 4) begin
                seen_pcin[n_seen] = wb_pcin;
                if (n_seen == 1) checkOutput("fill in_ready back", {31'd0, in_ready}, 32'd1);
                n_seen++;
            end
            tick();
        end
        checkOutput("fill drained count", n_seen, 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_seen)
                checkOutput($sformatf("fill pcin%0d", k), seen_pcin[k], 32'h1004 + 32'h10 * k);
        end
        exp_cnt += 4;
        checkOutput("fill retire_cnt", retire_cnt,     exp_cnt);
        checkOutput("fill empty",      {31'd0, empty}, 32'd1);

        // ---------------- forwarding, then flush with three entries ----------------
        wb_reg_done = 1'b0; pc_done = 1'b0;
        applyStimulus(mkComp(32'h500, 5'd7, 32'd1)); tick();
        applyStimulus(mkComp(32'h510, 5'd7, 32'd2)); tick();
        applyStimulus(mkComp(32'h520, 5'd9, 32'd3)); tick();
        in_valid = 1'b0;
        fwd_rs1 = 5'd7; fwd_rs2 = 5'd9;
        #1;
        checkOutput("fwd rs1=7 hit",  {31'd0, fwd_hit1}, 32'd1);
        checkOutput("fwd rs1=7 data", fwd_data1,         32'd2);
        checkOutput("fwd rs2=9 hit",  {31'd0, fwd_hit2}, 32'd1);
        checkOutput("fwd rs2=9 data", fwd_data2,         32'd3);
        fwd_rs1 = 5'd0;
        #1;
        checkOutput("fwd rs1=0 hit",  {31'd0, fwd_hit1}, 32'd0);
        flush = 1'b1;
        applyStimulus(mkComp(32'h530, 5'd9, 32'd4));
        tick();
        flush = 1'b0; in_valid = 1'b0;
        fwd_rs1 = 5'd7;
        #1;
        checkOutput("flush empty",     {31'd0, empty},     32'd0);
        checkOutput("flush pc_wen",    {31'd0, wb_pc_wen}, 32'd1);
        checkOutput("flush pcin",      wb_pcin,            32'h504);
        checkOutput("flush fwd7 hit",  {31'd0, fwd_hit1},  32'd1);
        checkOutput("flush fwd7 data", fwd_data1,          32'd1);
        checkOutput("flush fwd9 hit",  {31'd0, fwd_hit2},  32'd0);
        wb_reg_done = 1'b1; pc_done = 1'b1;
        tick();
        exp_cnt++;
        checkOutput("flush retire_cnt", retire_cnt,     exp_cnt);
        checkOutput("flush then empty", {31'd0, empty}, 32'd1);
        tick();
        checkOutput("flush no extra wen", {31'd0, wb_pc_wen}, 32'd0);

        // ---------------- reset mid-ISSUE ----------------
        wb_reg_done = 1'b0; pc_done = 1'b0;
        applyStimulus(mkComp(32'h700, 5'd2, 32'h42));
        tick();
        in_valid = 1'b0;
        checkOutput("midrst pc_wen before", {31'd0, wb_pc_wen}, 32'd1);
        rst = 1'b1;
        tick();
        checkResetState("midrst");
        rst = 1'b0;
        tick(); tick();
        checkOutput("midrst no wen later", {31'd0, wb_pc_wen | wb_reg_wen}, 32'd0);

        // ---------------- random traffic vs. reference model ----------------
        begin
            bit          head_wait, pc_acked, reg_acked;
            bit          exp_pc_wen, exp_reg_wen, fire_pc, fire_reg, ret, acc, was_empty;
            bit          pc_ok, reg_ok, h1, h2;
            logic [31:0] d1, d2;
            int unsigned mcnt;
            ment_t       ne;
            head_wait = 0; pc_acked = 0; reg_acked = 0; mcnt = 0;
            mq.delete();
            for (int c = 0; c < 600; c++) begin
                in_valid     = ($urandom_range(0, 9) < 6);
                in_pc        = $urandom & 32'hFFFF_FFFC;
                in_rd        = 5'($urandom_range(0, 7));
                in_jmp       = 1'($urandom_range(0, 1));
                in_target    = $urandom;
                in_link      = 1'($urandom_range(0, 1));
                in_load      = 1'($urandom_range(0, 1));
                in_load_data = $urandom;
                in_computed  = 1'($urandom_range(0, 1));
                in_value     = $urandom;
                flush        = ($urandom_range(0, 24) == 0);
                pc_done      = ($urandom_range(0, 2) == 0);
                wb_reg_done  = ($urandom_range(0, 2) == 0);
                fwd_rs1      = 5'($urandom_range(0, 7));
                fwd_rs2      = 5'($urandom_range(0, 7));
                #1;

                exp_pc_wen  = (mq.size() > 0) && !head_wait && !pc_acked;
                exp_reg_wen = (mq.size() > 0) && !head_wait && mq[0].rd_wen && !reg_acked;
                h1 = 0; d1 = 0; h2 = 0; d2 = 0;
                foreach (mq[i]) begin
                    if (mq[i].rd_wen && fwd_rs1 != 0 && mq[i].rd == fwd_rs1) begin h1 = 1; d1 = mq[i].data; end
                    if (mq[i].rd_wen && fwd_rs2 != 0 && mq[i].rd == fwd_rs2) begin h2 = 1; d2 = mq[i].data; end
                end

                checkOutput("rnd in_ready",   {31'd0, in_ready},   {31'd0, mq.size() < 4});
                checkOutput("rnd empty",      {31'd0, empty},      {31'd0, mq.size() == 0});
                checkOutput("rnd pc_wen",     {31'd0, wb_pc_wen},  {31'd0, exp_pc_wen});
                checkOutput("rnd reg_wen",    {31'd0, wb_reg_wen}, {31'd0, exp_reg_wen});
                checkOutput("rnd retire_cnt", retire_cnt,          mcnt);
                checkOutput("rnd fwd_hit1",   {31'd0, fwd_hit1},   {31'd0, h1});
                checkOutput("rnd fwd_data1",  fwd_data1,           d1);
                checkOutput("rnd fwd_hit2",   {31'd0, fwd_hit2},   {31'd0, h2});
                checkOutput("rnd fwd_data2",  fwd_data2,           d2);
                if (exp_pc_wen)  checkOutput("rnd pcin",    wb_pcin,             mq[0].npc);
                if (exp_reg_wen) begin
                    checkOutput("rnd rd_addr", {27'd0, wb_rd_addr}, {27'd0, mq[0].rd});
                    checkOutput("rnd rd_din",  wb_rd_din,           mq[0].data);
                end

                // Advance the model across the coming clock edge.
                fire_pc  = exp_pc_wen && pc_done;
                fire_reg = exp_reg_wen && wb_reg_done;
                pc_ok    = pc_acked || fire_pc;
                reg_ok   = reg_acked || fire_reg || ((mq.size() > 0) && !mq[0].rd_wen);
                ret      = (mq.size() > 0) && !head_wait && pc_ok && reg_ok;
                acc      = in_valid && (mq.size() < 4) && !flush;
                was_empty = (mq.size() == 0);
                ne.npc    = in_jmp ? in_target : in_pc + 32'd4;
                ne.rd     = in_rd;
                ne.rd_wen = (in_computed || in_link || in_load) && (in_rd != 0);
                ne.data   = in_computed ? in_value : (in_link ? in_pc + 32'd4 : (in_load ? in_load_data : 32'd0));
                if (flush) while (mq.size() > 1) void'(mq.pop_back());
                if (ret) begin
                    void'(mq.pop_front());
                    mcnt++;
                    pc_acked = 0; reg_acked = 0; head_wait = 1;
                end else begin
                    pc_acked  = pc_acked || fire_pc;
                    reg_acked = reg_acked || fire_reg;
                    head_wait = 0;
                end
                if (acc) begin
                    mq.push_back(ne);
                    if (was_empty) head_wait = 0;
                end
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_wb_queue.md
Name: core_wb_queue

Overview:
- Parametrised writeback stage that succeeds the single-entry WB pipe.
- Accepts retired results from MEM through a valid/ready handshake and buffers them in a DEPTH-entry in-order queue.
- Drives the register-file and PC write ports from the queue head, holding each request until the matching done acknowledge.
- Provides newest-value forwarding of pending rd writes to the decode stage.

Parameters:
- XLEN, 32, data and PC width.
- DEPTH, 4, queue entries; power of two, at least 2.
- RA_W, 5, register address width.
- PC_STEP, 4, sequential PC increment.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM result valid.
- in_ready  out  1  queue can accept a result.
- in_pc  in  XLEN  PC of the retiring instruction.
- in_rd  in  RA_W  destination register.
- in_jmp  in  1  taken transfer.
- in_target  in  XLEN  jump target.
- in_link  in  1  write pc+PC_STEP to rd.
- in_load  in  1  write in_load_data to rd.
- in_load_data  in  XLEN  RAM read data.
- in_computed  in  1  write in_value to rd.
- in_value  in  XLEN  ALU result.
- flush  in  1  drop all non-head entries.
- wb_reg_wen  out  1  register write request.
- wb_rd_addr  out  RA_W  register address.
- wb_rd_din  out  XLEN  register data.
- wb_reg_done  in  1  register write acknowledge.
- wb_pc_wen  out  1  PC write request.
- wb_pcin  out  XLEN  next PC.
- pc_done  in  1  PC write acknowledge.
- fwd_rs1, fwd_rs2  in  RA_W each  forwarding query addresses.
- fwd_hit1, fwd_hit2  out  1 each  a pending write matches the query.
- fwd_data1, fwd_data2  out  XLEN each  newest pending data for the query.
- retire_cnt  out  32  count of retired entries.
- empty  out  1  queue empty.

Behaviour:
- Reset:
  - Queue empty; head and tail pointers 0.
  - in_ready=1, empty=1.
  - wb_reg_wen=0, wb_pc_wen=0.
  - wb_rd_addr=0, wb_rd_din=0, wb_pcin=0.
  - fwd_hit1/2=0, retire_cnt=0.
  - A reset mid-handshake drops all entries with no further wen pulses.
- Accept:
  - Enqueue on the rising edge when in_valid & in_ready.
  - in_ready = !full. There is no same-cycle pass-through, even when the head retires in that cycle.
- Entry formation at enqueue; widths wrap modulo 2^XLEN:
  - npc = in_jmp ? in_target : in_pc+PC_STEP.
  - Data priority: computed > link > load.
  - Link data = in_pc+PC_STEP.
  - rd_wen = (computed|link|load) & (in_rd!=0).
- Head state machine:
  - States:
    - IDLE: queue empty.
    - ISSUE: both requests outstanding.
    - WAIT_REG: PC acknowledged, register write outstanding.
    - WAIT_PC: register acknowledged, PC write outstanding.
  - An entry enqueued into an empty queue at edge N drives wen at cycle N+1 (latency 1).
  - On entering ISSUE: wb_pc_wen=1 and wb_reg_wen=rd_wen. Address, data and pcin hold the head fields and stay stable while any wen is high.
  - Each wen drops on the edge after its done is sampled high while that wen is high.
  - A done received while its wen is low is ignored.
  - Both dones in the same cycle: retire directly from ISSUE.
  - An entry with rd_wen=0 waits for pc_done only.
- Retire:
  - Pop the head, increment retire_cnt (wraps at 2^32), and move to ISSUE on the next entry or to IDLE.
  - Back-to-back entries: the next head's wen is asserted in the cycle after retire. Each wen is low for at least one cycle between entries.
- Full/empty:
  - Pointers carry one extra bit.
  - full when the addresses are equal and the extra bits differ.
  - Enqueue and retire in the same cycle while full: retire only, since in_ready=0.
- Flush:
  - Tail = head+1 if the head is in a handshake, else the queue empties.
  - The head's handshake completes normally.
  - flush with in_valid in the same cycle: flush wins and nothing is enqueued.
- Forwarding (combinational):
  - Searches valid entries with rd_wen whose rd equals the query.
  - Returns the youngest match; query 0 never hits.
  - The head counts as pending until retired.

Decomposition:
- Shared package core_pkg:
  - XLEN_DEF and RA_W_DEF.
  - PC_STEP_DEF.
  - Head-state enum {IDLE, ISSUE, WAIT_REG, WAIT_PC}.
  - wb_entry_t struct {rd, rd_wen, data, npc}.
- Sub-module core_wb_fwd_lookup: parametrised youngest-match search over the queue, instantiated once per read port.

Test Plan:
- Reset, then one computed entry: in_pc=0x100, rd=5, value=0xDEAD, done tied high.
  - Cycle +1: wb_reg_wen=1, addr 5, din 0xDEAD; wb_pc_wen=1, pcin 0x104.
  - Retire; retire_cnt=1.
- Link plus jump: in_pc=0x200, target 0x400, rd=1.
  - din 0x204, pcin 0x400.
  - Same entry with rd=0: wb_reg_wen stays 0, PC written.
- Staggered acks: pc_done at +2, wb_reg_done at +5.
  - wb_pc_wen falls at +3; wb_reg_wen holds its addr/data until +6.
  - Retire at +6.
- Fill: push 4 entries with dones held low.
  - in_ready=0 after the 4th; a 5th in_valid is not accepted.
  - Release the dones: retire in order with 4 distinct pcin values; in_ready returns after the first retire.
- Forwarding: enqueue rd=7 value 1, then rd=7 value 2, dones low.
  - fwd_rs1=7 gives hit with data 2.
  - fwd_rs1=0 gives no hit.
- Flush with 3 entries, head in ISSUE: only the head retires, then empty=1.
  - Assert rst mid-ISSUE: outputs at reset values on the next edge.
